// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_tx arbiter slice.
package uart_pkg;

    localparam int BYTE_W = 8;
    localparam logic [3:0] TAG_HI_DEFAULT = 4'hA;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_DONE = 3'd2,
        GAP       = 3'd3
    } state_t;

    // Tag byte identifying the source: upper nibble, a zero bit, then the requester index.
    function automatic logic [BYTE_W-1:0] make_tag(input logic [3:0] hi, input logic [2:0] id);
        return {hi, 1'b0, id};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for the uart_tx arbiter.
// The arbiter attaches through the slave modport, the environment through master.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]        i_req_valid;
    logic [BYTE_W*N_REQ-1:0] i_req_data;
    logic [N_REQ-1:0]        o_req_ready;
    logic                    o_tx_start;
    logic [BYTE_W-1:0]       o_tx_byte;
    logic                    i_tx_done;
    logic                    o_busy;
    logic [2:0]              o_grant_id;
    logic                    o_timeout_err;

    modport slave (
        input  i_req_valid, i_req_data, i_tx_done,
        output o_req_ready, o_tx_start, o_tx_byte, o_busy, o_grant_id, o_timeout_err
    );

    modport master (
        output i_req_valid, i_req_data, i_tx_done,
        input  o_req_ready, o_tx_start, o_tx_byte, o_busy, o_grant_id, o_timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate the valid vector so rr_ptr sits at
// bit 0, take the lowest set bit, then rotate the offset back to an index.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [PW-1:0]    rr_ptr,
    output logic             any_valid,
    output logic [PW-1:0]    grant
);

    logic [N_REQ-1:0] rotated;
    logic [PW-1:0]    offset;
    int               sum;

    assign any_valid = |valid;

    // Rotate, priority-encode the rotated vector, and map the winner back to its index.
    always_comb begin
        rotated = '0;
        offset  = '0;
        sum     = 0;
        grant   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = int'(rr_ptr) + i;
            if (sum >= N_REQ) sum = sum - N_REQ;
            rotated[i] = valid[PW'(sum)];
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) offset = PW'(i);
        end
        sum = int'(rr_ptr) + int'(offset);
        if (sum >= N_REQ) sum = sum - N_REQ;
        grant = PW'(sum);
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx between N_REQ byte producers.
// Each grant accepts one byte, optionally preceded by a source tag byte,
// drives the transmitter start/done handshake, then idles for a fixed gap.
// A watchdog abandons the frame if the transmitter never reports done.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int         N_REQ      = 4,
    parameter bit         SEND_TAG   = 1'b1,
    parameter logic [3:0] TAG_HI     = TAG_HI_DEFAULT,
    parameter int         GAP_CYCLES = 16,
    parameter int         TIMEOUT    = 200000
) (
    input  logic              i_Clock,
    input  logic              i_reset_n,
    uart_tx_arbiter_if.slave  bus
);

    localparam int PW = $clog2(N_REQ);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t            state, state_n;
    logic [PW-1:0]     rr_ptr, rr_ptr_n;
    logic [BYTE_W-1:0] data_q, data_n;
    logic [2:0]        grant_q, grant_n;
    logic [BYTE_W-1:0] tx_byte_q, tx_byte_n;
    logic              tag_phase, tag_phase_n;
    logic [WW-1:0]     wdog, wdog_n;
    logic [GW-1:0]     gap_cnt, gap_cnt_n;

    logic [N_REQ-1:0]  req_ready;
    logic              tx_start;
    logic              timeout_err;
    logic              any_valid;
    logic [PW-1:0]     pick;

    rr_picker #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_picker (
        .valid     (bus.i_req_valid),
        .rr_ptr    (rr_ptr),
        .any_valid (any_valid),
        .grant     (pick)
    );

    // Next-state and handshake outputs; every register holds unless a state says otherwise.
    always_comb begin
        state_n     = state;
        rr_ptr_n    = rr_ptr;
        data_n      = data_q;
        grant_n     = grant_q;
        tx_byte_n   = tx_byte_q;
        tag_phase_n = tag_phase;
        wdog_n      = wdog;
        gap_cnt_n   = gap_cnt;
        req_ready   = '0;
        tx_start    = 1'b0;
        timeout_err = 1'b0;

        case (state)
            IDLE: begin
                if (any_valid) begin
                    req_ready[pick] = 1'b1;
                    data_n          = bus.i_req_data[int'(pick)*BYTE_W +: BYTE_W];
                    grant_n         = 3'(pick);
                    rr_ptr_n        = (pick == PW'(N_REQ - 1)) ? '0 : pick + 1'b1;
                    if (SEND_TAG) begin
                        tx_byte_n   = make_tag(TAG_HI, 3'(pick));
                        tag_phase_n = 1'b1;
                    end else begin
                        tx_byte_n   = bus.i_req_data[int'(pick)*BYTE_W +: BYTE_W];
                        tag_phase_n = 1'b0;
                    end
                    state_n = SEND;
                end
            end

            SEND: begin
                tx_start = 1'b1;
                wdog_n   = '0;
                state_n  = WAIT_DONE;
            end

            WAIT_DONE: begin
                wdog_n = wdog + 1'b1;
                if (bus.i_tx_done) begin
                    if (tag_phase) begin
                        tag_phase_n = 1'b0;
                        tx_byte_n   = data_q;
                        state_n     = SEND;
                    end else begin
                        gap_cnt_n = '0;
                        state_n   = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end
                end else if (wdog == WD_LAST) begin
                    timeout_err = 1'b1;
                    tag_phase_n = 1'b0;
                    gap_cnt_n   = '0;
                    state_n     = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers, cleared immediately when reset asserts.
    always_ff @(posedge i_Clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            data_q    <= '0;
            grant_q   <= '0;
            tx_byte_q <= '0;
            tag_phase <= 1'b0;
            wdog      <= '0;
            gap_cnt   <= '0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            data_q    <= data_n;
            grant_q   <= grant_n;
            tx_byte_q <= tx_byte_n;
            tag_phase <= tag_phase_n;
            wdog      <= wdog_n;
            gap_cnt   <= gap_cnt_n;
        end
    end

    // The accept pulse is combinational from requester valid, so it is masked
    // while reset is held to keep every output quiet during reset.
    assign bus.o_req_ready   = req_ready & {N_REQ{i_reset_n}};
    assign bus.o_tx_start    = tx_start;
    assign bus.o_tx_byte     = tx_byte_q;
    assign bus.o_busy        = (state != IDLE);
    assign bus.o_grant_id    = grant_q;
    assign bus.o_timeout_err = timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one tagged instance with a 16-cycle gap
// and short watchdog, and one untagged instance with no gap.
module tb_uart_tx_arbiter;

    logic i_Clock   = 1'b0;
    logic i_reset_n = 1'b0;
    int   checks    = 0;
    int   failures  = 0;
    int   start_cnt_a = 0;
    int   start_base;
    logic early;

    uart_tx_arbiter_if #(.N_REQ(4)) bus_a ();
    uart_tx_arbiter_if #(.N_REQ(4)) bus_b ();

    uart_tx_arbiter #(
        .N_REQ(4), .SEND_TAG(1'b1), .TAG_HI(4'hA), .GAP_CYCLES(16), .TIMEOUT(50)
    ) dut_a (
        .i_Clock   (i_Clock),
        .i_reset_n (i_reset_n),
        .bus       (bus_a)
    );

    uart_tx_arbiter #(
        .N_REQ(4), .SEND_TAG(1'b0), .TAG_HI(4'hA), .GAP_CYCLES(0), .TIMEOUT(50)
    ) dut_b (
        .i_Clock   (i_Clock),
        .i_reset_n (i_reset_n),
        .bus       (bus_b)
    );

    // 100 MHz clock.
    always #5 i_Clock = ~i_Clock;

    // Count start pulses of the tagged instance, sampled mid-cycle.
    always @(negedge i_Clock) begin
        if (bus_a.o_tx_start === 1'b1) start_cnt_a <= start_cnt_a + 1;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL global_timeout observed=stalled expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_Clock);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data);
        bus_a.i_req_valid = valid;
        bus_a.i_req_data  = data;
        #1;
    endtask

    initial begin
        bus_a.i_req_valid = '0;
        bus_a.i_req_data  = '0;
        bus_a.i_tx_done   = 1'b0;
        bus_b.i_req_valid = '0;
        bus_b.i_req_data  = '0;
        bus_b.i_tx_done   = 1'b0;

        // Reset state
        #2;
        checkOutput("rst_busy",    32'(bus_a.o_busy),        32'h0);
        checkOutput("rst_start",   32'(bus_a.o_tx_start),    32'h0);
        checkOutput("rst_byte",    32'(bus_a.o_tx_byte),     32'h00);
        checkOutput("rst_grant",   32'(bus_a.o_grant_id),    32'h0);
        checkOutput("rst_timeout", 32'(bus_a.o_timeout_err), 32'h0);
        applyStimulus(4'hF, 32'h0);
        checkOutput("rst_ready_masked", 32'(bus_a.o_req_ready), 32'h0);
        applyStimulus(4'h0, 32'h0);
        tick(2);
        i_reset_n = 1'b1;
        tick(1);

        // Single requester 2, tagged frame, done 10 clocks after each start
        applyStimulus(4'b0100, 32'h445C2211);
        checkOutput("t1_ready", 32'(bus_a.o_req_ready), 32'h4);
        start_base = start_cnt_a;
        tick(1);
        bus_a.i_req_valid = '0;
        checkOutput("t1_start_tag", 32'(bus_a.o_tx_start), 32'h1);
        checkOutput("t1_tag_byte",  32'(bus_a.o_tx_byte),  32'hA2);
        checkOutput("t1_grant",     32'(bus_a.o_grant_id), 32'h2);
        checkOutput("t1_busy",      32'(bus_a.o_busy),     32'h1);
        tick(1);
        checkOutput("t1_start_once", 32'(bus_a.o_tx_start), 32'h0);
        checkOutput("t1_tag_held",   32'(bus_a.o_tx_byte),  32'hA2);
        tick(9);
        bus_a.i_tx_done = 1'b1;
        tick(1);
        bus_a.i_tx_done = 1'b0;
        checkOutput("t1_start_data", 32'(bus_a.o_tx_start), 32'h1);
        checkOutput("t1_data_byte",  32'(bus_a.o_tx_byte),  32'h5C);
        tick(10);
        bus_a.i_tx_done = 1'b1;
        tick(1);
        bus_a.i_tx_done = 1'b0;
        checkOutput("t1_busy_gap_first", 32'(bus_a.o_busy), 32'h1);
        tick(15);
        checkOutput("t1_busy_gap_last", 32'(bus_a.o_busy), 32'h1);
        tick(1);
        checkOutput("t1_busy_fall", 32'(bus_a.o_busy), 32'h0);
        checkOutput("t1_start_count", 32'(start_cnt_a - start_base), 32'd2);

        // Watchdog abort on requester 1 (leaves rr_ptr at 2)
        applyStimulus(4'b0010, 32'h00007700);
        checkOutput("t4_ready", 32'(bus_a.o_req_ready), 32'h2);
        start_base = start_cnt_a;
        tick(1);
        bus_a.i_req_valid = '0;
        checkOutput("t4_tag_byte", 32'(bus_a.o_tx_byte), 32'hA1);
        early = 1'b0;
        for (int k = 1; k < 50; k++) begin
            tick(1);
            if (bus_a.o_timeout_err !== 1'b0) early = 1'b1;
        end
        checkOutput("t4_no_early_timeout", 32'(early), 32'h0);
        tick(1);
        checkOutput("t4_timeout_pulse", 32'(bus_a.o_timeout_err), 32'h1);
        tick(1);
        checkOutput("t4_timeout_once", 32'(bus_a.o_timeout_err), 32'h0);
        checkOutput("t4_no_data_start", 32'(bus_a.o_tx_start), 32'h0);
        checkOutput("t4_busy_gap", 32'(bus_a.o_busy), 32'h1);
        tick(16);
        checkOutput("t4_idle", 32'(bus_a.o_busy), 32'h0);
        checkOutput("t4_start_count", 32'(start_cnt_a - start_base), 32'd1);

        // rr_ptr=2 with requesters 0 and 1: search wraps to 0 first, then 1
        applyStimulus(4'b0011, 32'h0000B1B0);
        checkOutput("t3_ready_wrap", 32'(bus_a.o_req_ready), 32'h1);
        tick(1);
        bus_a.i_req_valid = 4'b0010;
        checkOutput("t3_grant0",   32'(bus_a.o_grant_id), 32'h0);
        checkOutput("t3_tag0",     32'(bus_a.o_tx_byte),  32'hA0);
        tick(1);
        bus_a.i_tx_done = 1'b1;
        tick(1);
        bus_a.i_tx_done = 1'b0;
        checkOutput("t3_data0", 32'(bus_a.o_tx_byte), 32'hB0);
        tick(1);
        bus_a.i_tx_done = 1'b1;
        tick(1);
        bus_a.i_tx_done = 1'b0;
        tick(16);
        checkOutput("t3_ready_next", 32'(bus_a.o_req_ready), 32'h2);

        // Done on the same cycle the watchdog would expire
        tick(1);
        bus_a.i_req_valid = '0;
        checkOutput("t5_grant1", 32'(bus_a.o_grant_id), 32'h1);
        checkOutput("t5_tag1",   32'(bus_a.o_tx_byte),  32'hA1);
        early = 1'b0;
        for (int k = 1; k < 50; k++) begin
            tick(1);
            if (bus_a.o_timeout_err !== 1'b0) early = 1'b1;
        end
        tick(1);
        bus_a.i_tx_done = 1'b1;
        #1;
        checkOutput("t5_no_timeout", 32'(bus_a.o_timeout_err), 32'h0);
        tick(1);
        bus_a.i_tx_done = 1'b0;
        checkOutput("t5_no_early_timeout", 32'(early), 32'h0);
        checkOutput("t5_data_start", 32'(bus_a.o_tx_start), 32'h1);
        checkOutput("t5_data_byte",  32'(bus_a.o_tx_byte),  32'hB1);
        tick(1);
        bus_a.i_tx_done = 1'b1;
        tick(1);
        bus_a.i_tx_done = 1'b0;
        tick(16);

        // Reset pulse while waiting for done; rr_ptr must return to 0
        applyStimulus(4'b0010, 32'h0000D100);
        tick(1);
        bus_a.i_req_valid = '0;
        tick(1);
        #2;
        i_reset_n = 1'b0;
        bus_a.i_req_valid = 4'b0101;
        #1;
        checkOutput("t6_busy",    32'(bus_a.o_busy),        32'h0);
        checkOutput("t6_start",   32'(bus_a.o_tx_start),    32'h0);
        checkOutput("t6_byte",    32'(bus_a.o_tx_byte),     32'h00);
        checkOutput("t6_grant",   32'(bus_a.o_grant_id),    32'h0);
        checkOutput("t6_ready",   32'(bus_a.o_req_ready),   32'h0);
        checkOutput("t6_timeout", 32'(bus_a.o_timeout_err), 32'h0);
        start_base = start_cnt_a;
        tick(2);
        checkOutput("t6_no_start_in_reset", 32'(start_cnt_a - start_base), 32'd0);
        i_reset_n = 1'b1;
        #1;
        checkOutput("t6_ready_req0", 32'(bus_a.o_req_ready), 32'h1);
        tick(1);
        bus_a.i_req_valid = '0;
        checkOutput("t6_grant_req0", 32'(bus_a.o_grant_id), 32'h0);
        checkOutput("t6_tag_req0",   32'(bus_a.o_tx_byte),  32'hA0);

        // Untagged instance, all requesters valid, no gap: strict rotation
        bus_b.i_req_valid = 4'hF;
        bus_b.i_req_data  = 32'h13121110;
        #1;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t2_ready_%0d", i), 32'(bus_b.o_req_ready), 32'(1 << (i % 4)));
            tick(1);
            checkOutput($sformatf("t2_start_%0d", i), 32'(bus_b.o_tx_start), 32'h1);
            checkOutput($sformatf("t2_byte_%0d", i),  32'(bus_b.o_tx_byte),  32'h10 + 32'(i % 4));
            checkOutput($sformatf("t2_grant_%0d", i), 32'(bus_b.o_grant_id), 32'(i % 4));
            tick(1);
            bus_b.i_tx_done = 1'b1;
            #1;
            checkOutput($sformatf("t2_busy_%0d", i), 32'(bus_b.o_busy), 32'h1);
            tick(1);
            bus_b.i_tx_done = 1'b0;
            checkOutput($sformatf("t2_idle_%0d", i), 32'(bus_b.o_busy), 32'h0);
        end
        bus_b.i_req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
